otbn_start_stop_seq: RTL and testbench

// - Sequences one OTBN run: URND reseed handshake -> core start -> run -> secure wipe -> halt.
// - Drives the WDR/GPR wipe write ports and ISPR clear; locks permanently after any fatal error.
// - Sits between the OTBN top-level command logic and otbn_core.

---
 rtl/otbn_start_stop_seq_pkg.sv | 21 ++
 rtl/otbn_start_stop_seq_if.sv | 38 +++
 rtl/otbn_start_stop_seq.sv | 118 +++++++++++
 tb/tb_otbn_start_stop_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/otbn_start_stop_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : otbn_start_stop_seq_pkg
// Brief  : Shared types and constants for the OTBN start/stop sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package otbn_start_stop_seq_pkg;

    localparam int c_NWDR   = 32;
    localparam int c_WDR_AW = 5;

    typedef enum logic [2:0] {
        SEQ_HALT         = 3'd0,
        SEQ_URND_REFRESH = 3'd1,
        SEQ_RUNNING      = 3'd2,
        SEQ_WIPE         = 3'd3,
        SEQ_LOCKED       = 3'd4
    } otbn_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/otbn_start_stop_seq_if.sv
`default_nettype none
// ============================================================================
// Module : otbn_start_stop_seq_if
// Brief  : Command, URND, core and wipe signals around the start/stop sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface otbn_start_stop_seq_if;

    logic                                          start_i;
    logic                                          fatal_err_i;
    logic                                          urnd_reseed_req_o;
    logic                                          urnd_reseed_ack_i;
    logic                                          core_start_o;
    logic                                          core_done_i;
    logic                                          wipe_we_o;
    logic [otbn_start_stop_seq_pkg::c_WDR_AW-1:0]  wipe_addr_o;
    logic                                          wipe_ispr_clr_o;
    logic                                          idle_o;
    logic                                          busy_o;
    logic                                          done_o;
    logic                                          locked_o;
    logic                                          reseed_timeout_o;

    // master: the sequencer itself; slave: host command logic, URND and core
    modport master (
        input  start_i, fatal_err_i, urnd_reseed_ack_i, core_done_i,
        output urnd_reseed_req_o, core_start_o, wipe_we_o, wipe_addr_o,
               wipe_ispr_clr_o, idle_o, busy_o, done_o, locked_o, reseed_timeout_o
    );

    modport slave (
        output start_i, fatal_err_i, urnd_reseed_ack_i, core_done_i,
        input  urnd_reseed_req_o, core_start_o, wipe_we_o, wipe_addr_o,
               wipe_ispr_clr_o, idle_o, busy_o, done_o, locked_o, reseed_timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/otbn_start_stop_seq.sv
`default_nettype none
// ============================================================================
// Module : otbn_start_stop_seq
// Brief  : Sequences one OTBN run: URND reseed, core start, run, wipe, halt/lock.
// Rev    : 1.0  initial release
// ============================================================================
module otbn_start_stop_seq
    import otbn_start_stop_seq_pkg::*;
#(
    parameter int NUM_WIPE       = c_NWDR,
    parameter int RESEED_TIMEOUT = 1024
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    otbn_start_stop_seq_if.master      bus
);

    localparam int c_TMO_W = (RESEED_TIMEOUT > 0) ? $clog2(RESEED_TIMEOUT + 1) : 1;
    localparam logic [c_WDR_AW-1:0] c_WIPE_LAST = c_WDR_AW'(NUM_WIPE - 1);

    otbn_seq_state_e      r_state;
    logic [c_WDR_AW-1:0]  r_wipe_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_lock;
    logic                 r_timeout;
    logic                 r_core_start;
    logic                 w_tmo_expired;
    logic                 w_wipe_last;

    generate
        if (RESEED_TIMEOUT > 0) begin : g_tmo_on
            assign w_tmo_expired = (r_tmo_cnt == c_TMO_W'(RESEED_TIMEOUT - 1));
        end else begin : g_tmo_off
            assign w_tmo_expired = 1'b0;
        end
    endgenerate

    assign w_wipe_last = (r_wipe_cnt == c_WIPE_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= SEQ_HALT;
            r_wipe_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_lock       <= 1'b0;
            r_timeout    <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                SEQ_HALT: begin
                    if (bus.fatal_err_i) begin
                        r_state <= SEQ_WIPE;
                        r_lock  <= 1'b1;
                    end else if (bus.start_i) begin
                        r_state   <= SEQ_URND_REFRESH;
                        r_tmo_cnt <= '0;
                    end
                end
                SEQ_URND_REFRESH: begin
                    // fatal beats ack, and ack beats a timeout expiring this cycle
                    if (bus.fatal_err_i) begin
                        r_state <= SEQ_WIPE;
                        r_lock  <= 1'b1;
                    end else if (bus.urnd_reseed_ack_i) begin
                        r_state      <= SEQ_RUNNING;
                        r_core_start <= 1'b1;
                    end else if (w_tmo_expired) begin
                        r_state   <= SEQ_WIPE;
                        r_lock    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end
                SEQ_RUNNING: begin
                    if (bus.fatal_err_i) begin
                        r_state <= SEQ_WIPE;
                        r_lock  <= 1'b1;
                    end else if (bus.core_done_i) begin
                        r_state <= SEQ_WIPE;
                    end
                end
                SEQ_WIPE: begin
                    if (bus.fatal_err_i) begin
                        r_lock <= 1'b1;
                    end
                    if (w_wipe_last) begin
                        r_wipe_cnt <= '0;
                        r_state    <= (r_lock || bus.fatal_err_i) ? SEQ_LOCKED : SEQ_HALT;
                    end else begin
                        r_wipe_cnt <= r_wipe_cnt + c_WDR_AW'(1);
                    end
                end
                SEQ_LOCKED: begin
                    r_state <= SEQ_LOCKED;
                end
                default: begin
                    r_state <= SEQ_LOCKED;
                end
            endcase
        end
    end

    assign bus.urnd_reseed_req_o = (r_state == SEQ_URND_REFRESH);
    assign bus.core_start_o      = r_core_start;
    assign bus.wipe_we_o         = (r_state == SEQ_WIPE);
    assign bus.wipe_addr_o       = (r_state == SEQ_WIPE) ? r_wipe_cnt : '0;
    assign bus.wipe_ispr_clr_o   = (r_state == SEQ_WIPE) && (r_wipe_cnt == '0);
    assign bus.idle_o            = (r_state == SEQ_HALT);
    assign bus.busy_o            = (r_state == SEQ_URND_REFRESH) || (r_state == SEQ_RUNNING) ||
                                   (r_state == SEQ_WIPE);
    assign bus.done_o            = (r_state == SEQ_WIPE) && w_wipe_last && !r_lock;
    assign bus.locked_o          = (r_state == SEQ_LOCKED);
    assign bus.reseed_timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_otbn_start_stop_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_otbn_start_stop_seq
// Brief  : Directed cycle-by-cycle vectors for otbn_start_stop_seq (ReseedTimeout=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_otbn_start_stop_seq;

    logic clk;
    logic rst_n;

    otbn_start_stop_seq_if u_if ();

    otbn_start_stop_seq #(
        .NUM_WIPE       (32),
        .RESEED_TIMEOUT (8)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs: {req, core_start, we, ispr_clr, idle, busy, done, locked, timeout, addr[4:0]}
    typedef struct {
        bit          st;
        bit          ft;
        bit          ak;
        bit          cd;
        bit          rn;
        logic [13:0] e;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [13:0] o(bit req, bit cs, bit we, bit clr, bit idle, bit busy,
                                      bit dn, bit lk, bit tmo, int addr);
        return {req, cs, we, clr, idle, busy, dn, lk, tmo, 5'(addr)};
    endfunction

    function automatic logic [13:0] e_idle();    return o(0,0,0,0,1,0,0,0,0,0); endfunction
    function automatic logic [13:0] e_req();     return o(1,0,0,0,0,1,0,0,0,0); endfunction
    function automatic logic [13:0] e_run(bit cs); return o(0,cs,0,0,0,1,0,0,0,0); endfunction
    function automatic logic [13:0] e_lock(bit tmo); return o(0,0,0,0,0,0,0,1,tmo,0); endfunction
    function automatic logic [13:0] e_wipe0(bit tmo); return o(0,0,1,1,0,1,0,0,tmo,0); endfunction

    task automatic add(bit st, bit ft, bit ak, bit cd, bit rn, logic [13:0] e, string nm);
        vec_t v;
        v.st = st; v.ft = ft; v.ak = ak; v.cd = cd; v.rn = rn; v.e = e; v.nm = nm;
        vecs.push_back(v);
    endtask

    // start in Halt, then n_req further refresh cycles without ack
    task automatic add_start(int n_req);
        add(1,0,0,0,1, e_req(), "start");
        for (int i = 0; i < n_req; i++) add(0,0,0,0,1, e_req(), $sformatf("req%0d", i));
    endtask

    // rows observing wipe indices 1..31 plus the row leaving Wipe
    task automatic add_wipe_rest(bit lock, bit tmo, int fatal_k, int st_k);
        for (int k = 1; k <= 31; k++) begin
            bit lk_k;
            lk_k = lock || (fatal_k >= 0 && fatal_k < k);
            add(bit'((k-1) == st_k), bit'((k-1) == fatal_k), 0, 0, 1,
                o(0,0,1,0,0,1, (k == 31) && !lk_k, 0, tmo, k), $sformatf("wipe%0d", k));
        end
        if (lock || fatal_k >= 0) add(0,0,0,0,1, e_lock(tmo), "wipe_end_locked");
        else                      add(0,0,0,0,1, e_idle(), "wipe_end_halt");
    endtask

    task automatic apply(vec_t v);
        logic [13:0] got;
        u_if.start_i           = v.st;
        u_if.fatal_err_i       = v.ft;
        u_if.urnd_reseed_ack_i = v.ak;
        u_if.core_done_i       = v.cd;
        rst_n                  = v.rn;
        @(posedge clk);
        #1;
        got = {u_if.urnd_reseed_req_o, u_if.core_start_o, u_if.wipe_we_o, u_if.wipe_ispr_clr_o,
               u_if.idle_o, u_if.busy_o, u_if.done_o, u_if.locked_o, u_if.reseed_timeout_o,
               u_if.wipe_addr_o};
        n_vec++;
        if (got !== v.e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (req cs we clr idle busy done lk tmo addr)",
                     v.nm, got, v.e);
        end
    endtask

    initial begin
        u_if.start_i = 1'b0; u_if.fatal_err_i = 1'b0;
        u_if.urnd_reseed_ack_i = 1'b0; u_if.core_done_i = 1'b0;
        rst_n = 1'b0;

        // Reset dominates a simultaneous start
        add(1,0,0,0,0, e_idle(), "reset");
        add(0,0,0,0,0, e_idle(), "reset_hold");

        // Nominal run: start@0, ack@5, done@20, stray start/ack while Running and Wipe
        add_start(4);
        add(0,0,1,0,1, e_run(1), "ack");
        add(0,0,0,0,1, e_run(0), "run_first");
        add(1,0,0,0,1, e_run(0), "start_in_run");
        add(0,0,1,0,1, e_run(0), "ack_in_run");
        for (int c = 9; c <= 19; c++) add(0,0,0,0,1, e_run(0), $sformatf("run_c%0d", c));
        add(0,0,0,1,1, e_wipe0(0), "done_to_wipe");
        add_wipe_rest(0, 0, -1, 3);
        add(0,0,1,0,1, e_idle(), "ack_in_halt");

        // Ack in the timeout expiry cycle wins; then fatal in Running locks after full wipe
        add_start(7);
        add(0,0,1,0,1, e_run(1), "ack_at_expiry");
        add(0,0,0,0,1, e_run(0), "run_after_expiry");
        add(0,1,0,0,1, e_wipe0(0), "fatal_in_run");
        add_wipe_rest(1, 0, -1, -1);
        add(1,0,1,1,1, e_lock(0), "start_in_locked");
        add(0,0,0,0,0, e_idle(), "reset_from_locked");

        // Reseed timeout: no ack for 8 refresh cycles
        add_start(7);
        add(0,0,0,0,1, e_wipe0(1), "timeout_to_wipe");
        add_wipe_rest(1, 1, -1, -1);
        add(1,0,1,0,1, e_lock(1), "locked_sticky_tmo");
        add(0,0,0,0,0, e_idle(), "reset_clears_tmo");

        // core_done and fatal together: wipe then Locked, never done_o
        add_start(4);
        add(0,0,1,0,1, e_run(1), "ack2");
        add(0,1,0,1,1, e_wipe0(0), "done_and_fatal");
        add_wipe_rest(1, 0, -1, -1);
        add(0,0,0,0,0, e_idle(), "reset3");

        // Fatal in Halt beats start
        add(1,1,0,0,1, e_wipe0(0), "fatal_in_halt");
        add_wipe_rest(1, 0, -1, -1);
        add(0,0,0,0,0, e_idle(), "reset4");

        // Fatal mid-wipe does not restart the sweep but locks at the end
        add_start(4);
        add(0,0,1,0,1, e_run(1), "ack3");
        add(0,0,0,1,1, e_wipe0(0), "done3");
        add_wipe_rest(0, 0, 5, -1);
        add(0,0,0,0,0, e_idle(), "reset5");

        foreach (vecs[i]) apply(vecs[i]);

        // Hand-written: reset asserted while the sweep sits at index 10
        begin
            vec_t v;
            v.st = 1; v.ft = 0; v.ak = 0; v.cd = 0; v.rn = 1; v.e = e_req(); v.nm = "hs_start";
            apply(v);
            v.st = 0; v.ak = 1; v.e = e_run(1); v.nm = "hs_ack";
            apply(v);
            v.ak = 0; v.cd = 1; v.e = e_wipe0(0); v.nm = "hs_done";
            apply(v);
            v.cd = 0;
            for (int k = 1; k <= 10; k++) begin
                v.e = o(0,0,1,0,0,1,0,0,0,k); v.nm = $sformatf("hs_wipe%0d", k);
                apply(v);
            end
            v.rn = 0; v.e = e_idle(); v.nm = "hs_reset_mid_wipe";
            apply(v);
            v.rn = 1; v.st = 1; v.e = e_req(); v.nm = "hs_restart";
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
